// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS datapath/memory.
// Handshake: mem_read/mem_write are requests held with stable iord until mem_ready is sampled high on a clock edge.
interface multicycle_control_fsm_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       illegal_op;
  logic [3:0] state_o;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, state_o
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, state_o
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS sequencer: walks each instruction through fetch/decode/execute/
// memory/writeback and drives every datapath mux and enable, stalling on mem_ready.
module multicycle_control_fsm (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_control_fsm_if.master bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC     = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_ADDI_EX  = 4'd11,
    S_ADDI_WB  = 4'd12
  } state_t;

  state_t state;
  state_t next_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RST;
    else        state <= next_state;
  end

  assign bus.state_o = state;

  always_comb begin
    next_state         = state;
    bus.pc_write       = 1'b0;
    bus.pc_write_cond  = 1'b0;
    bus.iord           = 1'b0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.ir_write       = 1'b0;
    bus.mem_to_reg     = 1'b0;
    bus.reg_dst        = 1'b0;
    bus.reg_write      = 1'b0;
    bus.alu_src_a      = 1'b0;
    bus.alu_src_b      = 2'b00;
    bus.alu_op         = 2'b00;
    bus.pc_source      = 2'b00;
    bus.illegal_op     = 1'b0;

    case (state)
      S_RST: next_state = S_FETCH;

      // PC+4 is computed every fetch cycle but only committed with the instruction word.
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
        if (bus.mem_ready) next_state = S_DECODE;
      end

      S_DECODE: begin
        bus.alu_src_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: next_state = S_MEM_ADDR;
          OP_RTYPE:     next_state = S_EXEC;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
          OP_ADDI:      next_state = S_ADDI_EX;
          default: begin
            bus.illegal_op = 1'b1;
            next_state     = S_FETCH;
          end
        endcase
      end

      // Only lw/sw arrive here; anything else abandons the instruction.
      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        if (bus.opcode == OP_LW)      next_state = S_MEM_RD;
        else if (bus.opcode == OP_SW) next_state = S_MEM_WR;
        else                          next_state = S_FETCH;
      end

      S_MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
        if (bus.mem_ready) next_state = S_MEM_WB;
      end

      S_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        next_state     = S_FETCH;
      end

      S_MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
        if (bus.mem_ready) next_state = S_FETCH;
      end

      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
        next_state    = S_R_WB;
      end

      S_R_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
        next_state    = S_FETCH;
      end

      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
        next_state        = S_FETCH;
      end

      S_JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
        next_state    = S_FETCH;
      end

      S_ADDI_EX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        next_state    = S_ADDI_WB;
      end

      S_ADDI_WB: begin
        bus.reg_write = 1'b1;
        next_state    = S_FETCH;
      end

      default: next_state = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: instruction-level model expands each opcode into its
// expected state walk, a per-cycle compare checks state and controls, plus literal pins.
module tb_multicycle_control_fsm;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  // each entry: {expected state[3:0], mem_ready, opcode[5:0]}
  logic [10:0] exp_q[$];

  int nonfetch_cnt, fetch_cnt, mem_read_cnt, iord_cnt, ir_write_cnt;
  int pc_write_cnt, mem_write_cnt, illegal_cnt, reg_write_cnt;

  multicycle_control_fsm_if bus ();

  multicycle_control_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctrl_t dut_ctrl();
    ctrl_t c;
    c.pc_write      = bus.pc_write;
    c.pc_write_cond = bus.pc_write_cond;
    c.iord          = bus.iord;
    c.mem_read      = bus.mem_read;
    c.mem_write     = bus.mem_write;
    c.ir_write      = bus.ir_write;
    c.mem_to_reg    = bus.mem_to_reg;
    c.reg_dst       = bus.reg_dst;
    c.reg_write     = bus.reg_write;
    c.alu_src_a     = bus.alu_src_a;
    c.alu_src_b     = bus.alu_src_b;
    c.alu_op        = bus.alu_op;
    c.pc_source     = bus.pc_source;
    c.illegal_op    = bus.illegal_op;
    return c;
  endfunction

  // Control word the datapath needs in each step of an instruction.
  function automatic ctrl_t exp_ctrl(int st, logic mr, logic [5:0] opc);
    ctrl_t c;
    c = '0;
    case (st)
      1: begin
        c.mem_read = 1'b1; c.alu_src_b = 2'b01;
        c.ir_write = mr;   c.pc_write  = mr;
      end
      2: begin
        c.alu_src_b  = 2'b11;
        c.illegal_op = !(opc inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI});
      end
      3:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      4:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
      5:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      6:  begin c.mem_write = 1'b1; c.iord = 1'b1; end
      7:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      8:  begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      9:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1; c.pc_source = 2'b01; end
      10: begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
      11: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      12: begin c.reg_write = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_now(int st, logic mr, logic [5:0] opc);
    ctrl_t e, a;
    e = exp_ctrl(st, mr, opc);
    a = dut_ctrl();
    check("state_o", int'(bus.state_o), st);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL ctrl st=%0d: got %h expected %h at %0t", st, a, e, $time);
    end
    if (bus.state_o != 4'd1) nonfetch_cnt++; else fetch_cnt++;
    if (a.mem_read)   mem_read_cnt++;
    if (a.iord)       iord_cnt++;
    if (a.ir_write)   ir_write_cnt++;
    if (a.pc_write)   pc_write_cnt++;
    if (a.mem_write)  mem_write_cnt++;
    if (a.illegal_op) illegal_cnt++;
    if (a.reg_write)  reg_write_cnt++;
  endtask

  // driver: one clock per call, inputs applied after negedge, outputs sampled 1ns later
  task automatic step(int st, logic mr, logic [5:0] opc);
    @(negedge clk);
    bus.mem_ready = mr;
    bus.opcode    = opc;
    #1;
    compare_now(st, mr, opc);
  endtask

  function automatic logic [5:0] rnd_op();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(int st, logic mr, logic [5:0] opc);
    exp_q.push_back({4'(st), mr, opc});
  endfunction

  // Instruction-level model: expand an opcode into the cycle walk it must take.
  function automatic void plan_instr(logic [5:0] opc, int fwait, int mwait);
    for (int i = 0; i < fwait; i++) push(1, 1'b0, rnd_op());
    push(1, 1'b1, rnd_op());
    push(2, rnd_bit(), opc);
    case (opc)
      OP_RTYPE: begin push(7, rnd_bit(), rnd_op()); push(8, rnd_bit(), rnd_op()); end
      OP_LW: begin
        push(3, rnd_bit(), opc);
        for (int i = 0; i < mwait; i++) push(4, 1'b0, rnd_op());
        push(4, 1'b1, rnd_op());
        push(5, rnd_bit(), rnd_op());
      end
      OP_SW: begin
        push(3, rnd_bit(), opc);
        for (int i = 0; i < mwait; i++) push(6, 1'b0, rnd_op());
        push(6, 1'b1, rnd_op());
      end
      OP_BEQ:  push(9, rnd_bit(), rnd_op());
      OP_J:    push(10, rnd_bit(), rnd_op());
      OP_ADDI: begin push(11, rnd_bit(), rnd_op()); push(12, rnd_bit(), rnd_op()); end
      default: ;
    endcase
  endfunction

  task automatic clear_counts();
    nonfetch_cnt = 0; fetch_cnt = 0; mem_read_cnt = 0; iord_cnt = 0; ir_write_cnt = 0;
    pc_write_cnt = 0; mem_write_cnt = 0; illegal_cnt = 0; reg_write_cnt = 0;
  endtask

  task automatic run_instr(logic [5:0] opc, int fwait, int mwait);
    logic [10:0] item;
    clear_counts();
    plan_instr(opc, fwait, mwait);
    while (exp_q.size() != 0) begin
      item = exp_q.pop_front();
      step(int'(item[10:7]), item[6], item[5:0]);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.opcode    = 6'd0;
    bus.mem_ready = 1'b0;
    clear_counts();

    repeat (2) @(negedge clk);
    #1;
    compare_now(0, 1'b0, 6'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compare_now(0, 1'b0, 6'd0);

    // R-type, no stalls: 1,2,7,8
    run_instr(OP_RTYPE, 0, 0);
    check("r_latency", nonfetch_cnt + fetch_cnt, 4);
    check("r_reg_write_cycles", reg_write_cnt, 1);

    // lw with two wait cycles in MEM_RD
    run_instr(OP_LW, 0, 2);
    check("lw_wait_cycles", nonfetch_cnt + fetch_cnt, 7);
    check("lw_mem_read_cycles", mem_read_cnt, 4);
    check("lw_iord_cycles", iord_cnt, 3);

    // sw with fetch stalled three cycles
    run_instr(OP_SW, 3, 0);
    check("sw_fetch_cycles", fetch_cnt, 4);
    check("sw_ir_write_pulses", ir_write_cnt, 1);
    check("sw_pc_write_pulses", pc_write_cnt, 1);
    check("sw_mem_write_cycles", mem_write_cnt, 1);

    // sw with a stalled write
    run_instr(OP_SW, 0, 2);
    check("sw_wr_stall_cycles", mem_write_cnt, 3);

    // beq then j
    run_instr(OP_BEQ, 0, 0);
    check("beq_latency", nonfetch_cnt + fetch_cnt, 3);
    run_instr(OP_J, 0, 0);
    check("j_latency", nonfetch_cnt + fetch_cnt, 3);
    check("j_pc_write_cycles", pc_write_cnt, 2);

    // illegal opcode
    run_instr(OP_BAD, 0, 0);
    check("illegal_pulses", illegal_cnt, 1);
    check("illegal_reg_write", reg_write_cnt, 0);

    run_instr(OP_ADDI, 0, 0);
    check("addi_latency", nonfetch_cnt + fetch_cnt, 4);
    run_instr(OP_LW, 0, 0);
    check("lw_latency", nonfetch_cnt + fetch_cnt, 5);
    run_instr(OP_SW, 0, 0);
    check("sw_latency", nonfetch_cnt + fetch_cnt, 4);

    // async reset while in EXEC
    step(1, 1'b1, rnd_op());
    step(2, 1'b0, OP_RTYPE);
    step(7, 1'b1, rnd_op());
    #2;
    rst_n = 1'b0;
    #1;
    compare_now(0, bus.mem_ready, bus.opcode);
    check("reset_reg_write", int'(bus.reg_write), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compare_now(0, bus.mem_ready, bus.opcode);

    run_instr(OP_RTYPE, 1, 0);
    check("post_reset_r_cycles", nonfetch_cnt + fetch_cnt, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
